screen_scanner: RTL and testbench
=================================

SCREEN_SCANNER -- requirements
Module: screen_scanner

Interface
REQ-001 Parameter RAM_WORDS, default 128, number of 16-bit words in one frame buffer.
REQ-002 Parameter WORDS_PER_ROW, default 32, words per display row (512 pixels per row).
REQ-003 clock  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 scan_start  input  1  one-cycle request to scan one frame.
REQ-006 scan_abort  input  1  terminate the current frame immediately.
REQ-007 scan_ram_data  input  16  read data returned by the RAM stage.
REQ-008 scan_ram_address  output  7  word address presented to the RAM stage.
REQ-009 scan_ram_read  output  1  read strobe; 1 for exactly one cycle per fetched word.
REQ-010 scan_pixel  output  1  current pixel value, 1 = black.
REQ-011 scan_pixel_valid  output  1  scan_pixel is valid.
REQ-012 scan_pixel_ready  input  1  downstream accepts the pixel this cycle.
REQ-013 scan_row_end  output  1  the presented pixel is the last pixel of a row.
REQ-014 scan_frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.
REQ-015 scan_busy  output  1  high in every state except IDLE.

Function
REQ-016 The FSM shall have states IDLE, FETCH, LOAD and SHIFT.
REQ-017 In IDLE, scan_start=1 shall clear the word index to 0 and move to FETCH.
REQ-018 In FETCH, scan_ram_read=1 and scan_ram_address=word index for one cycle, then LOAD.
REQ-019 RAM read latency is one cycle: in LOAD, scan_ram_data is captured into a 16-bit shift register, the bit counter is cleared, and the FSM moves to SHIFT.
REQ-020 In SHIFT, scan_pixel_valid=1 and scan_pixel=shift register bit 0; pixel order within a word is LSB first (bit 0 leftmost).
REQ-021 A pixel transfers only when scan_pixel_valid and scan_pixel_ready are both 1; on a transfer the register shifts right by one and the bit counter increments.
REQ-022 While scan_pixel_ready=0, scan_pixel and scan_pixel_valid shall hold stable; no pixel is dropped or repeated.
REQ-023 scan_row_end=1 exactly while SHIFT presents bit 15 of a word whose index mod WORDS_PER_ROW = WORDS_PER_ROW-1.
REQ-024 On transfer of bit 15: if word index < RAM_WORDS-1, increment the index and go to FETCH; otherwise pulse scan_frame_done on the next cycle and go to IDLE.
REQ-025 The word index shall never exceed RAM_WORDS-1; no address wrap-around within a frame.
REQ-026 scan_start outside IDLE shall be ignored.
REQ-027 scan_abort=1 in any state shall force IDLE on the next edge, deassert valid/read, and suppress scan_frame_done.
REQ-028 scan_abort and scan_start asserted together in IDLE: abort wins; the FSM stays in IDLE.
REQ-029 scan_ram_read and scan_pixel_valid shall never be 1 in the same cycle.
REQ-030 A full frame without backpressure takes RAM_WORDS*18 cycles from start to scan_frame_done.

Reset
REQ-031 Reset shall force IDLE, word index 0, bit counter 0, shift register 0.
REQ-032 During and after reset, all outputs shall be 0 (scan_ram_address=0).
REQ-033 Reset mid-frame shall discard the frame with no scan_frame_done pulse.

Structure
REQ-034 Shared package hack_pkg holds RAM_WORDS, RAM_ADDR_W=7, WORD_W=16, WORDS_PER_ROW and the scanner state enumeration.
REQ-035 One sub-module, scan_shifter, implements the 16-bit load/shift register and the 4-bit bit counter with a last-bit flag.

Verification
REQ-036 Reset, then start with RAM word0=0x0001, others 0, ready held 1 -> first pixel 1, next 2047 pixels 0, frame_done exactly 2304 cycles after start.
REQ-037 Word 31=0x8000, ready 1 -> row_end coincides with pixel 511 (value 1); row_end asserted 4 times per frame.
REQ-038 Word0=0xA5A5, ready toggled 1/0 each cycle -> accepted pixel sequence 1,0,1,0,0,1,0,1,... with valid/pixel held during stalls.
REQ-039 Abort asserted in SHIFT at word 5 -> IDLE next cycle, valid 0, no frame_done; new start rescans from address 0.
REQ-040 Start pulsed again mid-frame, and abort+start together in IDLE -> both ignored; FSM and address sequence unaffected.
REQ-041 Reset asserted asynchronously mid-SHIFT -> all outputs 0 immediately, no frame_done afterwards.

Source files
------------

// File: rtl/hack_pkg.sv
// Shared constants and state encoding for the screen scanner.
package hack_pkg;

  localparam int RAM_WORDS     = 128;
  localparam int RAM_ADDR_W    = 7;
  localparam int WORD_W        = 16;
  localparam int WORDS_PER_ROW = 32;
  localparam int BIT_CNT_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_SHIFT
  } scan_state_e;

endpackage

// File: rtl/scan_shifter.sv
// 16-bit pixel shift register with a bit counter; presents bit 0 first
// and flags when the last bit of the word is being presented.
module scan_shifter
  import hack_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [WORD_W-1:0] data_i,
  output logic              bit_o,
  output logic              last_o
);

  logic [WORD_W-1:0]    sr_q, sr_d;
  logic [BIT_CNT_W-1:0] cnt_q, cnt_d;

  // Load replaces the word and restarts the count; shift consumes one pixel.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load_i) begin
      sr_d  = data_i;
      cnt_d = '0;
    end else if (shift_i) begin
      sr_d  = {1'b0, sr_q[WORD_W-1:1]};
      cnt_d = cnt_q + BIT_CNT_W'(1);
    end
  end

  // Register the shifter state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign bit_o  = sr_q[0];
  assign last_o = (cnt_q == '1);

endmodule

// File: rtl/screen_scanner.sv
// Frame-buffer scanner: fetches each word from RAM and streams its 16
// pixels LSB first over a valid/ready handshake, flagging row ends and
// pulsing frame_done after the final pixel of the frame.
module screen_scanner #(
  parameter int RAM_WORDS     = hack_pkg::RAM_WORDS,
  parameter int WORDS_PER_ROW = hack_pkg::WORDS_PER_ROW
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          scan_start,
  input  logic                          scan_abort,
  input  logic [hack_pkg::WORD_W-1:0]   scan_ram_data,
  output logic [hack_pkg::RAM_ADDR_W-1:0] scan_ram_address,
  output logic                          scan_ram_read,
  output logic                          scan_pixel,
  output logic                          scan_pixel_valid,
  input  logic                          scan_pixel_ready,
  output logic                          scan_row_end,
  output logic                          scan_frame_done,
  output logic                          scan_busy
);

  import hack_pkg::*;

  localparam logic [RAM_ADDR_W-1:0] LAST_IDX = RAM_ADDR_W'(RAM_WORDS - 1);
  localparam int                    ROW_LAST = WORDS_PER_ROW - 1;

  scan_state_e           state_q;
  logic [RAM_ADDR_W-1:0] idx_q;
  logic                  read_q;
  logic                  valid_q;
  logic                  busy_q;
  logic                  done_q;

  logic shift_bit;
  logic last_bit;
  logic load;
  logic xfer;
  logic row_tail;

  // Abort gates the shifter so an abandoned word never advances.
  assign load     = (state_q == ST_LOAD) && !scan_abort;
  assign xfer     = valid_q && scan_pixel_ready && !scan_abort;
  assign row_tail = ((int'(idx_q) % WORDS_PER_ROW) == ROW_LAST);

  scan_shifter u_shifter (
    .clk_i   (clock),
    .rst_i   (reset),
    .load_i  (load),
    .shift_i (xfer),
    .data_i  (scan_ram_data),
    .bit_o   (shift_bit),
    .last_o  (last_bit)
  );

  // Scan sequencer: IDLE -> FETCH -> LOAD -> SHIFT per word, abort overrides all.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      read_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (scan_abort) begin
        state_q <= ST_IDLE;
        read_q  <= 1'b0;
        valid_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (scan_start) begin
              idx_q   <= '0;
              state_q <= ST_FETCH;
              read_q  <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
          ST_FETCH: begin
            read_q  <= 1'b0;
            state_q <= ST_LOAD;
          end
          ST_LOAD: begin
            valid_q <= 1'b1;
            state_q <= ST_SHIFT;
          end
          ST_SHIFT: begin
            if (xfer && last_bit) begin
              valid_q <= 1'b0;
              if (idx_q < LAST_IDX) begin
                idx_q   <= idx_q + RAM_ADDR_W'(1);
                state_q <= ST_FETCH;
                read_q  <= 1'b1;
              end else begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign scan_ram_address = idx_q;
  assign scan_ram_read    = read_q;
  assign scan_pixel_valid = valid_q;
  assign scan_pixel       = valid_q & shift_bit;
  assign scan_row_end     = valid_q & last_bit & row_tail;
  assign scan_frame_done  = done_q;
  assign scan_busy        = busy_q;

endmodule

// File: tb/tb_screen_scanner.sv
// Directed/random bench for screen_scanner with a frame-level pixel model.
module tb_screen_scanner;

  localparam int RAM_WORDS = 128;
  localparam int WPR       = 32;
  localparam int PIX       = RAM_WORDS * 16;
  localparam int ROW_PIX   = WPR * 16;
  localparam int FRAME_CYC = RAM_WORDS * 18;

  logic        clock = 1'b0;
  logic        reset;
  logic        scan_start;
  logic        scan_abort;
  logic [15:0] scan_ram_data;
  logic [6:0]  scan_ram_address;
  logic        scan_ram_read;
  logic        scan_pixel;
  logic        scan_pixel_valid;
  logic        scan_pixel_ready;
  logic        scan_row_end;
  logic        scan_frame_done;
  logic        scan_busy;

  logic [15:0] mem [RAM_WORDS];

  int n_checks = 0;
  int n_fail   = 0;

  screen_scanner #(
    .RAM_WORDS     (RAM_WORDS),
    .WORDS_PER_ROW (WPR)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .scan_start       (scan_start),
    .scan_abort       (scan_abort),
    .scan_ram_data    (scan_ram_data),
    .scan_ram_address (scan_ram_address),
    .scan_ram_read    (scan_ram_read),
    .scan_pixel       (scan_pixel),
    .scan_pixel_valid (scan_pixel_valid),
    .scan_pixel_ready (scan_pixel_ready),
    .scan_row_end     (scan_row_end),
    .scan_frame_done  (scan_frame_done),
    .scan_busy        (scan_busy)
  );

  always #5 clock = ~clock;

  // RAM with one cycle of read latency
  always @(posedge clock) begin
    if (scan_ram_read) scan_ram_data <= mem[scan_ram_address];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Frame model: pixel p is bit (p mod 16) of word (p / 16), LSB leftmost.
  function automatic logic exp_pixel(input int p);
    logic [15:0] w;
    if (p >= PIX) return 1'b0;
    w = mem[p / 16];
    return w[p % 16];
  endfunction

  task automatic chk_quiet(input string tag, input bit with_addr);
    chk({tag, "_read"},    32'(scan_ram_read), 0);
    chk({tag, "_valid"},   32'(scan_pixel_valid), 0);
    chk({tag, "_pixel"},   32'(scan_pixel), 0);
    chk({tag, "_row_end"}, 32'(scan_row_end), 0);
    chk({tag, "_done"},    32'(scan_frame_done), 0);
    chk({tag, "_busy"},    32'(scan_busy), 0);
    if (with_addr) chk({tag, "_addr"}, 32'(scan_ram_address), 0);
  endtask

  task automatic fill_mem(input int kind);
    for (int i = 0; i < RAM_WORDS; i++) mem[i] = (kind == 0) ? 16'h0 : 16'($urandom);
  endtask

  // mode: 0 ready held 1, 1 ready toggling, 2 random ready.
  // abort_c / start_c: cycle (counted from the start edge) to pulse abort / start, -1 for none.
  task automatic run_frame(input int mode, input int abort_c, input int start_c);
    int  p, c, rows, last_x;
    bit  prev_stall, done_seen;
    logic prev_pix;
    p = 0; c = 0; rows = 0; last_x = -10; prev_stall = 0; prev_pix = 0; done_seen = 0;
    scan_abort = 0;
    scan_pixel_ready = 1;
    @(posedge clock); #1 scan_start = 1;
    @(posedge clock); #1 scan_start = 0;
    for (int guard = 0; guard < 4 * FRAME_CYC; guard++) begin
      case (mode)
        0:       scan_pixel_ready = 1;
        1:       scan_pixel_ready = ~scan_pixel_ready;
        default: scan_pixel_ready = ($urandom_range(0, 3) != 0);
      endcase
      scan_start = (c == start_c);
      scan_abort = (c == abort_c);
      @(negedge clock);
      chk("read_and_valid", 32'(scan_ram_read & scan_pixel_valid), 0);
      if (prev_stall) begin
        chk("stall_valid", 32'(scan_pixel_valid), 1);
        chk("stall_pixel", 32'(scan_pixel), 32'(prev_pix));
      end
      if (scan_ram_read) chk("read_addr", 32'(scan_ram_address), 32'(p / 16));
      if (scan_pixel_valid) begin
        chk("pixel_in_frame", 32'(p < PIX), 1);
        chk("pixel", 32'(scan_pixel), 32'(exp_pixel(p)));
        chk("row_end", 32'(scan_row_end), 32'((p % ROW_PIX) == ROW_PIX - 1));
      end else begin
        chk("row_end_invalid", 32'(scan_row_end), 0);
      end
      if (c == abort_c) begin
        @(posedge clock); #1 scan_abort = 0;
        @(negedge clock);
        chk_quiet("abort", 0);
        for (int k = 0; k < 20; k++) begin
          @(negedge clock);
          chk("abort_no_done", 32'(scan_frame_done), 0);
          chk("abort_idle", 32'(scan_busy), 0);
        end
        return;
      end
      if (scan_frame_done) begin
        chk("done_pixel_count", 32'(p), 32'(PIX));
        chk("done_latency", 32'(c), 32'(last_x + 1));
        chk("done_busy", 32'(scan_busy), 0);
        chk("row_end_count", 32'(rows), 32'(PIX / ROW_PIX));
        if (mode == 0) chk("frame_cycles", 32'(c), 32'(FRAME_CYC));
        done_seen = 1;
        break;
      end else begin
        chk("busy", 32'(scan_busy), 1);
      end
      prev_stall = scan_pixel_valid && !scan_pixel_ready;
      prev_pix   = scan_pixel;
      if (scan_pixel_valid && scan_pixel_ready) begin
        if (scan_row_end) rows++;
        last_x = c;
        p++;
      end
      @(posedge clock); #1;
      c++;
    end
    scan_start = 0;
    chk("frame_done_seen", 32'(done_seen), 1);
    @(negedge clock);
    chk("done_single_pulse", 32'(scan_frame_done), 0);
    chk("after_frame_busy", 32'(scan_busy), 0);
  endtask

  initial begin
    reset = 1; scan_start = 0; scan_abort = 0; scan_pixel_ready = 0; scan_ram_data = '0;
    fill_mem(0);
    #12;
    chk_quiet("in_reset", 1);
    @(posedge clock); #1 reset = 0;
    @(negedge clock);
    chk_quiet("post_reset", 1);

    // single black pixel at the top-left
    fill_mem(0); mem[0] = 16'h0001;
    run_frame(0, -1, -1);

    // last pixel of the first row black
    fill_mem(0); mem[31] = 16'h8000;
    run_frame(0, -1, -1);

    // alternating backpressure
    fill_mem(0); mem[0] = 16'hA5A5;
    run_frame(1, -1, -1);

    // abort while shifting word 5, then a fresh scan from address 0
    fill_mem(1);
    run_frame(0, 18 * 5 + 7, -1);
    run_frame(0, -1, -1);

    // start pulsed mid-frame is ignored
    fill_mem(1);
    run_frame(0, -1, 300);

    // abort and start together in IDLE: abort wins
    @(posedge clock); #1 scan_start = 1; scan_abort = 1;
    @(posedge clock); #1 scan_start = 0; scan_abort = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("abort_start_busy", 32'(scan_busy), 0);
      chk("abort_start_read", 32'(scan_ram_read), 0);
    end

    // asynchronous reset while shifting word 2
    scan_pixel_ready = 1;
    @(posedge clock); #1 scan_start = 1;
    @(posedge clock); #1 scan_start = 0;
    repeat (40) @(posedge clock);
    #3 reset = 1;
    #1 chk_quiet("async_reset", 1);
    @(posedge clock); @(posedge clock); #1 reset = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      chk("reset_no_done", 32'(scan_frame_done), 0);
      chk("reset_idle", 32'(scan_busy), 0);
    end

    // random data with random backpressure after recovery
    fill_mem(1);
    run_frame(2, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
